reg_dump_ctrl: RTL and testbench

Debug controller that halts the MIPS core, takes over the register-file read port, and streams all 32 architectural registers followed by the program counter over a valid/ready output. It sits beside the `MIPS` top level: it drives the core's halt input and the select of a read-address mux in front of `RF`, and gives benches and host logic a cycle-accurate end-of-program state dump without hierarchical peeking.

---
 rtl/reg_dump_ctrl.sv | 157 +++++++++++++++
 tb/tb_reg_dump_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_ctrl.sv
// Debug dump controller: halts the core, walks the register file read port and
// streams every register plus the PC over a valid/ready interface.
module reg_dump_ctrl #(
   parameter int unsigned NUM_REGS     = 32,
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned HALT_TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              halt_req,
   input  logic              halt_ack,
   output logic              rf_sel,
   output logic [4:0]        rf_raddr,
   input  logic [DATA_W-1:0] rf_rdata,
   input  logic [DATA_W-1:0] pc_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [5:0]        out_index,
   output logic [DATA_W-1:0] out_data,
   output logic              busy,
   output logic              done,
   output logic              error
);

   localparam int unsigned IDX_W   = 6;
   localparam int unsigned TO_BITS = $clog2(HALT_TIMEOUT + 1);
   localparam int unsigned TO_W    = (TO_BITS > 8) ? TO_BITS : 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HALT,
      S_READ,
      S_SEND,
      S_RELEASE
   } state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d, idx_nxt;
   logic [TO_W-1:0]   to_q, to_d;
   logic              halt_req_d, rf_sel_d, out_valid_d, busy_d, done_d, error_d;
   logic [4:0]        rf_raddr_d;
   logic [5:0]        out_index_d;
   logic [DATA_W-1:0] out_data_d;

   assign idx_nxt = idx_q + IDX_W'(1);

   // Next-state and next-output logic; every output is registered below.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      to_d        = to_q;
      halt_req_d  = halt_req;
      rf_sel_d    = 1'b0;
      rf_raddr_d  = rf_raddr;
      out_valid_d = out_valid;
      out_index_d = out_index;
      out_data_d  = out_data;
      busy_d      = busy;
      done_d      = 1'b0;
      error_d     = error;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d    = S_HALT;
               error_d    = 1'b0;
               idx_d      = '0;
               to_d       = '0;
               halt_req_d = 1'b1;
               busy_d     = 1'b1;
            end
         end
         S_HALT: begin
            if (halt_ack) begin
               state_d = S_READ;
               if (idx_q < IDX_W'(NUM_REGS)) begin
                  rf_sel_d   = 1'b1;
                  rf_raddr_d = idx_q[4:0];
               end
            end else if (to_q == TO_W'(HALT_TIMEOUT)) begin
               state_d    = S_IDLE;
               error_d    = 1'b1;
               done_d     = 1'b1;
               halt_req_d = 1'b0;
               busy_d     = 1'b0;
            end else begin
               to_d = to_q + TO_W'(1);
            end
         end
         S_READ: begin
            out_data_d  = (idx_q < IDX_W'(NUM_REGS)) ? rf_rdata : pc_in;
            out_index_d = idx_q;
            out_valid_d = 1'b1;
            state_d     = S_SEND;
         end
         S_SEND: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               if (idx_q == IDX_W'(NUM_REGS)) begin
                  state_d    = S_RELEASE;
                  halt_req_d = 1'b0;
               end else begin
                  idx_d   = idx_nxt;
                  state_d = S_READ;
                  if (idx_nxt < IDX_W'(NUM_REGS)) begin
                     rf_sel_d   = 1'b1;
                     rf_raddr_d = idx_nxt[4:0];
                  end
               end
            end
         end
         S_RELEASE: begin
            if (!halt_ack) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
               busy_d  = 1'b0;
            end
         end
         default: begin
            state_d    = S_IDLE;
            halt_req_d = 1'b0;
            busy_d     = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         to_q      <= '0;
         halt_req  <= 1'b0;
         rf_sel    <= 1'b0;
         rf_raddr  <= '0;
         out_valid <= 1'b0;
         out_index <= '0;
         out_data  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         to_q      <= to_d;
         halt_req  <= halt_req_d;
         rf_sel    <= rf_sel_d;
         rf_raddr  <= rf_raddr_d;
         out_valid <= out_valid_d;
         out_index <= out_index_d;
         out_data  <= out_data_d;
         busy      <= busy_d;
         done      <= done_d;
         error     <= error_d;
      end
   end

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// Scoreboard bench for reg_dump_ctrl: stimulus queues expected words, a
// negedge monitor pops and compares on every accepted output word.
module tb_reg_dump_ctrl;

   localparam int unsigned DW = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic          halt_req;
   logic          halt_ack;
   logic          rf_sel;
   logic [4:0]    rf_raddr;
   logic [DW-1:0] rf_rdata;
   logic [DW-1:0] pc_in;
   logic          out_valid;
   logic          out_ready;
   logic [5:0]    out_index;
   logic [DW-1:0] out_data;
   logic          busy;
   logic          done;
   logic          error;

   typedef struct packed {
      logic [5:0]    idx;
      logic [DW-1:0] data;
   } exp_t;

   exp_t          exp_q[$];
   logic [DW-1:0] rf[32];
   logic [2:0]    ack_sr;
   int            ack_mode;
   logic          ready_toggle;
   int            n_cmp, n_fail, words, done_cnt;
   logic          stall_prev;
   logic [5:0]    hold_idx;
   logic [DW-1:0] hold_data;

   always #5 clk = ~clk;

   reg_dump_ctrl #(.NUM_REGS(32), .DATA_W(DW), .HALT_TIMEOUT(10)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .halt_req(halt_req), .halt_ack(halt_ack),
      .rf_sel(rf_sel), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
      .pc_in(pc_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_index(out_index), .out_data(out_data),
      .busy(busy), .done(done), .error(error)
   );

   // Core model: combinational RF read, ack follows halt_req (optionally 3 cycles late on rise, or never).
   assign rf_rdata = rf[rf_raddr];
   always @(posedge clk) ack_sr <= {ack_sr[1:0], halt_req};
   assign halt_ack = (ack_mode == 0) ? halt_req :
                     (ack_mode == 1) ? (halt_req & ack_sr[2]) : 1'b0;

   always @(posedge clk) begin
      #1;
      if (ready_toggle) out_ready = ~out_ready;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", nm, act, req);
      end
   endtask

   // Monitor: pops on every handshake, and checks words are held across stalls.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         stall_prev = 1'b0;
      end else begin
         if (done) done_cnt++;
         if (out_valid) begin
            if (stall_prev) begin
               chk("hold_index", 64'(out_index), 64'(hold_idx));
               chk("hold_data", 64'(out_data), 64'(hold_data));
            end
            if (out_ready) begin
               words++;
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_fail++;
                  $display("FAIL extra_word: got index %0d data %h required no word", out_index, out_data);
               end else begin
                  e = exp_q.pop_front();
                  chk("word_index", 64'(out_index), 64'(e.idx));
                  chk("word_data", 64'(out_data), 64'(e.data));
               end
               stall_prev = 1'b0;
            end else begin
               stall_prev = 1'b1;
               hold_idx   = out_index;
               hold_data  = out_data;
            end
         end else begin
            stall_prev = 1'b0;
         end
      end
   end

   // One dump: queue expected words, pulse start, wait (bounded) for done.
   task automatic run_dump(input string nm, input int exp_done, input int nwords,
                           input logic exp_err, input int restart_at, input int reset_at);
      int   n;
      int   w0;
      int   d0;
      logic aborted;
      exp_t e;
      for (int k = 0; k < nwords; k++) begin
         e.idx  = 6'(k);
         e.data = (k == 0) ? 32'h0 : (k == 32) ? 32'h0000_0040 : 32'h1000_0000 + 32'(k);
         exp_q.push_back(e);
      end
      w0      = words;
      d0      = done_cnt;
      aborted = 1'b0;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      chk({nm, "_busy_after_start"}, 64'(busy), 64'd1);
      chk({nm, "_halt_req_after_start"}, 64'(halt_req), 64'd1);
      chk({nm, "_error_cleared"}, 64'(error), 64'd0);
      n = 0;
      while (!done && n < 200 && !aborted) begin
         @(posedge clk);
         n++;
         #1;
         start = (n == restart_at);
         if (ack_mode == 1 && n < 4) chk({nm, "_rf_sel_before_ack"}, 64'(rf_sel), 64'd0);
         if (n == reset_at) begin
            chk({nm, "_index_before_reset"}, 64'(out_index), 64'd12);
            chk({nm, "_valid_before_reset"}, 64'(out_valid), 64'd1);
            rst_n = 1'b0;
            #1;
            chk({nm, "_halt_req_in_reset"}, 64'(halt_req), 64'd0);
            chk({nm, "_valid_in_reset"}, 64'(out_valid), 64'd0);
            chk({nm, "_busy_in_reset"}, 64'(busy), 64'd0);
            aborted = 1'b1;
         end
      end
      start = 1'b0;
      if (aborted) begin
         repeat (2) @(posedge clk);
         #1 rst_n = 1'b1;
         repeat (5) @(posedge clk);
         chk({nm, "_no_done"}, 64'(done_cnt - d0), 64'd0);
      end else begin
         if (exp_done >= 0) chk({nm, "_done_cycle"}, 64'(n), 64'(exp_done));
         chk({nm, "_error"}, 64'(error), 64'(exp_err));
         repeat (3) @(posedge clk);
         #1;
         chk({nm, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
         chk({nm, "_idle_after"}, 64'(busy), 64'd0);
      end
      chk({nm, "_word_count"}, 64'(words - w0), 64'(nwords));
      chk({nm, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
      exp_q.delete();
   endtask

   initial begin
      n_cmp        = 0;
      n_fail       = 0;
      words        = 0;
      done_cnt     = 0;
      stall_prev   = 1'b0;
      ack_mode     = 0;
      ready_toggle = 1'b0;
      rst_n        = 1'b0;
      start        = 1'b0;
      out_ready    = 1'b1;
      pc_in        = 32'h0000_0040;
      for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'h0 : 32'h1000_0000 + 32'(i);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_halt_req", 64'(halt_req), 64'd0);
      chk("rst_rf_sel", 64'(rf_sel), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_error", 64'(error), 64'd0);
      chk("rst_rf_raddr", 64'(rf_raddr), 64'd0);
      chk("rst_out_index", 64'(out_index), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      run_dump("base", 68, 33, 1'b0, -1, -1);

      ready_toggle = 1'b1;
      run_dump("backpressure", -1, 33, 1'b0, -1, -1);
      ready_toggle = 1'b0;
      @(posedge clk); #2 out_ready = 1'b1;

      ack_mode = 2;
      run_dump("timeout", 11, 0, 1'b1, -1, -1);
      ack_mode = 0;

      run_dump("restart_ignored", 68, 33, 1'b0, 12, -1);
      run_dump("reset_mid", -1, 12, 1'b0, -1, 26);
      run_dump("after_reset", 68, 33, 1'b0, -1, -1);

      ack_mode = 1;
      run_dump("late_ack", 71, 33, 1'b0, -1, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
